cpu_state_seq: RTL

- Parametrised multi-cycle CPU control sequencer; successor to the fixed IDLE/FETCH/EXEC controller.
- Drives cpu datapath phase selection.
- Adds configurable fetch length, variable execute length (up to MAX_EXEC phases via cont), memory-stall freeze, halt/resume, single-cycle interrupt entry state, and a retired-instruction counter.

---
 rtl/cpu_state_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cpu_state_seq.sv
// Multi-cycle CPU control sequencer: IDLE/FETCH/EXEC/HALTED/IRQ with sub-phase
// counting, memory-stall freeze, halt/resume, interrupt entry and retire counter.
module cpu_state_seq #(
    parameter int FETCH_CYCLES = 2,
    parameter int MAX_EXEC     = 4,
    parameter int PH_W         = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cont,
    input  logic             halt,
    input  logic             resume,
    input  logic             irq,
    input  logic             mem_wait,
    output logic [2:0]       cs,
    output logic [PH_W-1:0]  phase,
    output logic             instr_done,
    output logic             irq_ack,
    output logic             halted,
    output logic             exec_ovf,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_HALTED = 3'd3,
        S_IRQ    = 3'd4
    } state_t;

    localparam logic [PH_W-1:0] FETCH_LAST = PH_W'(FETCH_CYCLES - 1);
    localparam logic [PH_W-1:0] EXEC_LAST  = PH_W'(MAX_EXEC - 1);

    state_t          state, state_nxt;
    logic [PH_W-1:0] ph, ph_nxt;
    logic            complete;
    logic            ovf_hit;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ph    <= '0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
        end
    end

    // Retire bookkeeping; instr_done is the registered completion strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_done <= 1'b0;
            exec_ovf   <= 1'b0;
            retired    <= '0;
        end else begin
            instr_done <= complete;
            if (ovf_hit)
                exec_ovf <= 1'b1;
            if (complete)
                retired <= retired + 1'b1;
        end
    end

    // Next-state logic; mem_wait freezes FETCH/EXEC entirely
    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        complete  = 1'b0;
        ovf_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_FETCH;
                    ph_nxt    = '0;
                end
            end
            S_FETCH: begin
                if (!mem_wait) begin
                    if (ph == FETCH_LAST) begin
                        state_nxt = S_EXEC;
                        ph_nxt    = '0;
                    end else begin
                        ph_nxt = ph + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (!mem_wait) begin
                    if (cont && (ph < EXEC_LAST)) begin
                        ph_nxt = ph + 1'b1;
                    end else begin
                        // cont at the last allowed phase still retires, but is flagged
                        complete = 1'b1;
                        ovf_hit  = cont;
                        ph_nxt   = '0;
                        if (halt)
                            state_nxt = S_HALTED;
                        else if (irq)
                            state_nxt = S_IRQ;
                        else
                            state_nxt = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                if (resume) begin
                    state_nxt = S_FETCH;
                    ph_nxt    = '0;
                end
            end
            S_IRQ: begin
                state_nxt = S_FETCH;
                ph_nxt    = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                ph_nxt    = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        cs      = state;
        phase   = ph;
        irq_ack = (state == S_IRQ);
        halted  = (state == S_HALTED);
    end

endmodule
